// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane helper
// used by ahb_slave and its register file.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [31:0] AHB_DEFAULT_BASE = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

    // Little-endian byte lanes touched by a transfer of the given size.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << lane;
            HSIZE_HALF: lane_mask = 4'b0011 << {lane[1], 1'b0};
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slave_regfile.sv
// MEM_DEPTH x 32 register memory: asynchronous clear, per-byte write
// enables and a combinational read port.
module ahb_slave_regfile #(
    parameter  int MEM_DEPTH = 16,
    localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic [3:0]       wbe,
    input  logic [IDX_W-1:0] widx,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (wbe[k]) begin
                    mem[widx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/ahb_slave.sv
// AHB-Lite responder backed by a word memory, with configurable wait states.
// Define AHB_SLV_ERR_EN to give illegal accesses the two-cycle ERROR response.
module ahb_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = AHB_DEFAULT_BASE,
    parameter int          MEM_DEPTH   = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hreadyin,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);

    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_DEPTH);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_e       state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic             is_xfer, accept, legal_in;
    logic [31:0]      offset;
    logic             vld_p1, write_p1, legal_p1;
    logic [2:0]       size_p1;
    logic [1:0]       lane_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             data_cyc;
    logic [3:0]       wbe;
    logic [31:0]      mem_rdata;

    always_comb begin
        is_xfer = 1'b0;
        case (htrans)
            HTRANS_NONSEQ, HTRANS_SEQ: is_xfer = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  is_xfer = 1'b0;
            default:                   is_xfer = 1'b0;
        endcase
    end

    assign accept = hreadyin & is_xfer;
    // Offset arithmetic wraps, so one unsigned compare covers both window edges.
    assign offset = haddr - BASE_ADDR;

    always_comb begin
        legal_in = (offset < WIN_BYTES);
        case (hsize)
            HSIZE_BYTE: ;
            HSIZE_HALF: if (haddr[0])             legal_in = 1'b0;
            HSIZE_WORD: if (haddr[1:0] != 2'b00)  legal_in = 1'b0;
            default:                              legal_in = 1'b0;
        endcase
    end

    // Address phase -> data phase (p1)
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (hreadyout) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge hclk) begin
        if (accept) begin
            write_p1 <= hwrite;
            size_p1  <= hsize;
            lane_p1  <= haddr[1:0];
            idx_p1   <= haddr[IDX_W+1:2];
            legal_p1 <= legal_in;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state)
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (cnt == 4'd0) state_nxt = ST_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
`ifdef AHB_SLV_ERR_EN
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_nxt = ST_ERR2;
            end
`endif
            default: begin
                // IDLE and ERR2 both end a data phase and may take a pipelined address.
`ifdef AHB_SLV_ERR_EN
                if (state == ST_ERR2) hresp = HRESP_ERROR;
`endif
                state_nxt = ST_IDLE;
                if (accept && legal_in && (WAIT_STATES > 0)) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end
`ifdef AHB_SLV_ERR_EN
                if (accept && !legal_in) state_nxt = ST_ERR1;
`endif
            end
        endcase
    end

    assign data_cyc = (state == ST_IDLE) && vld_p1 && legal_p1;
    assign wbe      = (data_cyc && write_p1) ? lane_mask(size_p1, lane_p1) : 4'b0000;
    assign hrdata   = (data_cyc && !write_p1) ? mem_rdata : 32'h0;

    ahb_slave_regfile #(
        .MEM_DEPTH(MEM_DEPTH)
    ) u_regfile (
        .hclk   (hclk),
        .hresetn(hresetn),
        .wbe    (wbe),
        .widx   (idx_p1),
        .wdata  (hwdata),
        .ridx   (idx_p1),
        .rdata  (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_slave.sv
// Bench for ahb_slave: three instances (0, 2 and 3 wait states) checked every
// cycle against a transaction-level model, plus hand-computed literal checks.
`timescale 1ns/1ps
module tb_ahb_slave;

    localparam int          ND    = 3;
    localparam int          WSL [ND] = '{0, 2, 3};
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;

`ifdef AHB_SLV_ERR_EN
    localparam logic [31:0] ILL_STALL = 32'd1;
    localparam logic [31:0] ILL_RESP  = 32'd1;
`else
    localparam logic [31:0] ILL_STALL = 32'd0;
    localparam logic [31:0] ILL_RESP  = 32'd0;
`endif

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hreadyin_b  [ND];
    logic [1:0]  htrans_b    [ND];
    logic        hwrite_b    [ND];
    logic [2:0]  hsize_b     [ND];
    logic [31:0] haddr_b     [ND];
    logic [31:0] hwdata_b    [ND];
    logic        hreadyout_b [ND];
    logic [1:0]  hresp_b     [ND];
    logic [31:0] hrdata_b    [ND];

    always #5 hclk = ~hclk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        ahb_slave #(
            .BASE_ADDR  (BASE),
            .MEM_DEPTH  (DEPTH),
            .WAIT_STATES(WSL[g])
        ) u_dut (
            .hclk     (hclk),
            .hresetn  (hresetn),
            .hreadyin (hreadyin_b[g]),
            .htrans   (htrans_b[g]),
            .hwrite   (hwrite_b[g]),
            .hsize    (hsize_b[g]),
            .haddr    (haddr_b[g]),
            .hwdata   (hwdata_b[g]),
            .hreadyout(hreadyout_b[g]),
            .hresp    (hresp_b[g]),
            .hrdata   (hrdata_b[g])
        );
    end

    // One expected bus cycle: ready, response, and (for the final data cycle) what it does.
    typedef struct packed {
        logic       rdy;
        logic [1:0] resp;
        logic       fin;
        logic       wr;
        logic [3:0] idx;
        logic [3:0] be;
    } cyc_t;

    cyc_t        q     [ND][$];
    logic [31:0] mem_m [ND][DEPTH];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic cyc_t mk(logic rdy, logic [1:0] resp, logic fin, logic wr,
                                logic [3:0] idx, logic [3:0] be);
        cyc_t c;
        c.rdy = rdy; c.resp = resp; c.fin = fin; c.wr = wr; c.idx = idx; c.be = be;
        return c;
    endfunction

    function automatic bit legal_m(logic [31:0] a, logic [2:0] s);
        logic [31:0] off;
        off = a - BASE;
        if (s > 3'd2) return 1'b0;
        if (off >= 32'(4 * DEPTH)) return 1'b0;
        return (a % (32'd1 << s)) == 32'd0;
    endfunction

    function automatic logic [3:0] be_m(logic [31:0] a, logic [2:0] s);
        int nbytes;
        nbytes = 1 << s;
        return 4'(((1 << nbytes) - 1) << a[1:0]);
    endfunction

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %h, want %h", nm, d, act, exp);
        end
    endtask

    // Model: consumes one expected cycle per clock, commits writes, schedules accepted transfers.
    initial begin
        for (int d = 0; d < ND; d++) begin
            hreadyin_b[d] = 1'b1;
            for (int w = 0; w < DEPTH; w++) mem_m[d][w] = 32'h0;
        end
        forever begin
            @(posedge hclk);
            for (int d = 0; d < ND; d++) begin
                cyc_t        e;
                logic [31:0] a;
                logic [2:0]  s;
                if (!hresetn) begin
                    q[d].delete();
                    for (int w = 0; w < DEPTH; w++) mem_m[d][w] = 32'h0;
                end else begin
                    if (q[d].size() > 0) begin
                        e = q[d].pop_front();
                        if (e.fin && e.wr) begin
                            for (int k = 0; k < 4; k++) begin
                                if (e.be[k]) mem_m[d][e.idx][8*k +: 8] = hwdata_b[d][8*k +: 8];
                            end
                        end
                    end
                    if (hreadyin_b[d] && htrans_b[d][1]) begin
                        a = haddr_b[d];
                        s = hsize_b[d];
                        if (legal_m(a, s)) begin
                            repeat (WSL[d]) q[d].push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0));
                            q[d].push_back(mk(1'b1, 2'b00, 1'b1, hwrite_b[d], 4'((a - BASE) >> 2), be_m(a, s)));
                        end else begin
`ifdef AHB_SLV_ERR_EN
                            q[d].push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, 4'h0, 4'h0));
                            q[d].push_back(mk(1'b1, 2'b01, 1'b0, 1'b0, 4'h0, 4'h0));
`else
                            q[d].push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0));
`endif
                        end
                    end
                end
            end
            #1;
            for (int d = 0; d < ND; d++) begin
                hreadyin_b[d] = (q[d].size() > 0) ? q[d][0].rdy : 1'b1;
            end
        end
    end

    // Compare every DUT against the model in the middle of every cycle.
    initial begin
        forever begin
            @(negedge hclk);
            for (int d = 0; d < ND; d++) begin
                cyc_t        e;
                logic [31:0] er;
                e  = (q[d].size() > 0) ? q[d][0] : mk(1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 4'h0);
                er = (e.fin && !e.wr) ? mem_m[d][e.idx] : 32'h0;
                chk("hreadyout", d, 32'(hreadyout_b[d]), 32'(e.rdy));
                chk("hresp",     d, 32'(hresp_b[d]),     32'(e.resp));
                chk("hrdata",    d, hrdata_b[d],         er);
            end
        end
    end

    task automatic addr_phase(int d, logic wr, logic [2:0] s, logic [31:0] a, logic [31:0] wd);
        bit r;
        bit ok;
        ok = 1'b0;
        htrans_b[d] = 2'b10;
        hwrite_b[d] = wr;
        hsize_b[d]  = s;
        haddr_b[d]  = a;
        for (int i = 0; i < 40 && !ok; i++) begin
            r = hreadyin_b[d];
            @(posedge hclk);
            if (r) ok = 1'b1;
        end
        #1;
        htrans_b[d] = 2'b00;
        if (wr) hwdata_b[d] = wd;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL addr_timeout dut%0d: got no accept, want accept within 40 cycles", d);
        end
    endtask

    task automatic data_phase(int d, output logic [31:0] rd, output logic [31:0] rs,
                              output logic [31:0] stalls);
        bit done;
        done = 1'b0;
        rd = 32'h0; rs = 32'h0; stalls = 32'h0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge hclk);
            if (hreadyout_b[d]) begin
                rd = hrdata_b[d];
                rs = 32'(hresp_b[d]);
                done = 1'b1;
            end else begin
                stalls++;
            end
        end
        #1;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL data_timeout dut%0d: got no ready, want ready within 40 cycles", d);
        end
    endtask

    task automatic xfer(int d, logic wr, logic [2:0] s, logic [31:0] a, logic [31:0] wd,
                        output logic [31:0] rd, output logic [31:0] rs, output logic [31:0] st);
        addr_phase(d, wr, s, a, wd);
        data_phase(d, rd, rs, st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rs, st;
        for (int d = 0; d < ND; d++) begin
            htrans_b[d] = 2'b00; hwrite_b[d] = 1'b0; hsize_b[d] = 3'd0;
            haddr_b[d] = 32'h0;  hwdata_b[d] = 32'h0;
        end
        hresetn = 1'b0;
        repeat (2) @(negedge hclk);
        chk("rst_hreadyout", 0, 32'(hreadyout_b[0]), 32'd1);
        chk("rst_hresp",     0, 32'(hresp_b[0]),     32'd0);
        chk("rst_hrdata",    0, hrdata_b[0],         32'h0);
        #1 hresetn = 1'b1;
        @(negedge hclk); #1;

        // Zero wait states: byte write/read, pipelined word write then read.
        xfer(0, 1'b1, 3'd0, 32'h8000_0001, 32'h0000_8000, rd, rs, st);
        chk("byte_wr_resp", 0, rs, 32'd0);
        chk("byte_wr_stall", 0, st, 32'd0);
        xfer(0, 1'b0, 3'd0, 32'h8000_0001, 32'h0, rd, rs, st);
        chk("byte_rd_data", 0, rd, 32'h0000_8000);
        chk("byte_rd_resp", 0, rs, 32'd0);
        xfer(0, 1'b1, 3'd2, 32'h8000_0004, 32'h1234_5678, rd, rs, st);
        xfer(0, 1'b0, 3'd2, 32'h8000_0004, 32'h0, rd, rs, st);
        chk("pipe_rd_data", 0, rd, 32'h1234_5678);
        chk("pipe_rd_stall", 0, st, 32'd0);
        xfer(0, 1'b1, 3'd1, 32'h8000_0006, 32'hABCD_0000, rd, rs, st);
        xfer(0, 1'b0, 3'd2, 32'h8000_0004, 32'h0, rd, rs, st);
        chk("half_hi_data", 0, rd, 32'hABCD_5678);
        xfer(0, 1'b1, 3'd2, 32'h8000_003C, 32'hCAFE_F00D, rd, rs, st);
        xfer(0, 1'b0, 3'd2, 32'h8000_003C, 32'h0, rd, rs, st);
        chk("last_word_data", 0, rd, 32'hCAFE_F00D);

        // Illegal accesses: just past the window, far out, misaligned, bad size.
        xfer(0, 1'b0, 3'd2, 32'h8000_0040, 32'h0, rd, rs, st);
        chk("past_end_resp", 0, rs, ILL_RESP);
        chk("past_end_stall", 0, st, ILL_STALL);
        chk("past_end_data", 0, rd, 32'h0);
        xfer(0, 1'b0, 3'd2, 32'h9000_0000, 32'h0, rd, rs, st);
        chk("oor_rd_resp", 0, rs, ILL_RESP);
        chk("oor_rd_data", 0, rd, 32'h0);
        xfer(0, 1'b1, 3'd2, 32'h9000_0000, 32'hFFFF_FFFF, rd, rs, st);
        chk("oor_wr_resp", 0, rs, ILL_RESP);
        chk("oor_wr_stall", 0, st, ILL_STALL);
        xfer(0, 1'b1, 3'd1, 32'h8000_0001, 32'hFFFF_FFFF, rd, rs, st);
        chk("misalign_resp", 0, rs, ILL_RESP);
        xfer(0, 1'b0, 3'd2, 32'h8000_0000, 32'h0, rd, rs, st);
        chk("after_ill_data", 0, rd, 32'h0000_8000);
        chk("after_ill_stall", 0, st, 32'd0);
        xfer(0, 1'b0, 3'd3, 32'h8000_0000, 32'h0, rd, rs, st);
        chk("bad_size_resp", 0, rs, ILL_RESP);
        chk("bad_size_data", 0, rd, 32'h0);
        repeat (2) @(negedge hclk); #1;

        // Two wait states.
        xfer(1, 1'b1, 3'd2, 32'h8000_0008, 32'hDEAD_BEEF, rd, rs, st);
        chk("ws2_wr_stall", 1, st, 32'd2);
        chk("ws2_wr_resp", 1, rs, 32'd0);
        xfer(1, 1'b0, 3'd2, 32'h8000_0008, 32'h0, rd, rs, st);
        chk("ws2_rd_data", 1, rd, 32'hDEAD_BEEF);
        chk("ws2_rd_stall", 1, st, 32'd2);
        chk("model_ws2_word", 1, mem_m[1][2], 32'hDEAD_BEEF);
        xfer(1, 1'b1, 3'd2, 32'h8000_0004, 32'h1234_5678, rd, rs, st);
        xfer(1, 1'b0, 3'd2, 32'h8000_0004, 32'h0, rd, rs, st);
        chk("ws2_pipe_data", 1, rd, 32'h1234_5678);
        chk("ws2_pipe_stall", 1, st, 32'd2);
        xfer(1, 1'b0, 3'd2, 32'h9000_0000, 32'h0, rd, rs, st);
        chk("ws2_ill_stall", 1, st, ILL_STALL);
        chk("ws2_ill_resp", 1, rs, ILL_RESP);
        repeat (2) @(negedge hclk); #1;

        // Three wait states, reset asserted while the write is stalled.
        addr_phase(2, 1'b1, 3'd2, 32'h8000_000C, 32'hA5A5_A5A5);
        @(negedge hclk); #1;
        hresetn = 1'b0;
        #1;
        chk("mid_rst_hreadyout", 2, 32'(hreadyout_b[2]), 32'd1);
        chk("mid_rst_hresp",     2, 32'(hresp_b[2]),     32'd0);
        chk("mid_rst_hrdata",    2, hrdata_b[2],         32'h0);
        @(negedge hclk); #1;
        hresetn = 1'b1;
        @(negedge hclk); #1;
        xfer(2, 1'b0, 3'd2, 32'h8000_000C, 32'h0, rd, rs, st);
        chk("post_rst_data", 2, rd, 32'h0);
        chk("post_rst_stall", 2, st, 32'd3);
        xfer(0, 1'b0, 3'd2, 32'h8000_0004, 32'h0, rd, rs, st);
        chk("post_rst_clear", 0, rd, 32'h0);
        repeat (2) @(negedge hclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
